// File: rtl/beamforming_pkg.sv
// Shared types and constants for the beamforming scheduler.
//   bf_state_e : scheduler FSM encoding (3 bits)
//   LED_WIDTH  : width of the engine LED direction pattern
//   fits_width : true when a value is representable in an unsigned field of the given width
package beamforming_pkg;

  localparam int unsigned LED_WIDTH = 8;

  typedef enum logic [2:0] {
    StIdle    = 3'd0,
    StClear   = 3'd1,
    StFill    = 3'd2,
    StArm     = 3'd3,
    StCompute = 3'd4,
    StHold    = 3'd5
  } bf_state_e;

  function automatic bit fits_width(input int unsigned value, input int unsigned width);
    return (width >= 32) || (value < (32'd1 << width));
  endfunction

endpackage

// File: rtl/sample_level_detect.sv
// Combinational sound-level detector for both I2S channels.
//   i_left_data / i_right_data : two's complement samples
//   o_hit                      : |left| >= THRESHOLD or |right| >= THRESHOLD
// Magnitude is formed one bit wider than the sample so the most negative value is exact.
module sample_level_detect #(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned THRESHOLD  = 1024
) (
  input  logic [DATA_WIDTH-1:0] i_left_data,
  input  logic [DATA_WIDTH-1:0] i_right_data,
  output logic                  o_hit
);

  localparam logic [DATA_WIDTH:0] THR = (DATA_WIDTH + 1)'(THRESHOLD);

  function automatic logic [DATA_WIDTH:0] abs_ext(input logic [DATA_WIDTH-1:0] x);
    logic [DATA_WIDTH:0] s;
    s = {x[DATA_WIDTH-1], x};
    return x[DATA_WIDTH-1] ? (~s + 1'b1) : s;
  endfunction

  logic [DATA_WIDTH:0] w_mag_left;
  logic [DATA_WIDTH:0] w_mag_right;

  assign w_mag_left  = abs_ext(i_left_data);
  assign w_mag_right = abs_ext(i_right_data);
  assign o_hit       = (w_mag_left >= THR) || (w_mag_right >= THR);

endmodule

// File: rtl/beamforming_scheduler.sv
// Sequences one beamforming engine: clear, wait for history fill, arm on loud sound,
// trigger, wait for the engine result (with timeout), latch and hold the LED pattern.
//   i_clk, i_rst_n (async, active-low), i_enable        : control
//   i_left_data, i_right_data                            : I2S samples (shared with engine)
//   i_bf_valid, i_bf_led_pattern                         : engine result
//   o_bf_reset, o_bf_trigger                             : engine control (registered)
//   o_led_out, o_result_valid, o_busy, o_timeout_err     : status (registered)
module beamforming_scheduler
  import beamforming_pkg::*;
#(
  parameter int unsigned DATA_WIDTH     = 16,
  parameter int unsigned CNT_WIDTH      = 24,
  parameter int unsigned RESET_CYCLES   = 4,
  parameter int unsigned FILL_CYCLES    = 90,
  parameter int unsigned THRESHOLD      = 1024,
  parameter int unsigned TIMEOUT_CYCLES = 256,
  parameter int unsigned HOLD_CYCLES    = 1000000
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_enable,
  input  logic [DATA_WIDTH-1:0] i_left_data,
  input  logic [DATA_WIDTH-1:0] i_right_data,
  input  logic                  i_bf_valid,
  input  logic [LED_WIDTH-1:0]  i_bf_led_pattern,
  output logic                  o_bf_reset,
  output logic                  o_bf_trigger,
  output logic [LED_WIDTH-1:0]  o_led_out,
  output logic                  o_result_valid,
  output logic                  o_busy,
  output logic                  o_timeout_err
);

  if (!fits_width(RESET_CYCLES, CNT_WIDTH) || !fits_width(FILL_CYCLES, CNT_WIDTH) ||
      !fits_width(TIMEOUT_CYCLES, CNT_WIDTH) || !fits_width(HOLD_CYCLES, CNT_WIDTH) ||
      RESET_CYCLES == 0 || FILL_CYCLES == 0 || TIMEOUT_CYCLES == 0 || HOLD_CYCLES == 0)
  begin : g_param_check
    $error("beamforming_scheduler: cycle parameter zero or wider than CNT_WIDTH");
  end

  // Last counter value of each timed state; the state exits on that cycle.
  localparam logic [CNT_WIDTH-1:0] RESET_LAST   = CNT_WIDTH'(RESET_CYCLES - 1);
  localparam logic [CNT_WIDTH-1:0] FILL_LAST    = CNT_WIDTH'(FILL_CYCLES - 1);
  localparam logic [CNT_WIDTH-1:0] TIMEOUT_LAST = CNT_WIDTH'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_WIDTH-1:0] HOLD_LAST    = CNT_WIDTH'(HOLD_CYCLES - 1);

  bf_state_e              r_state, w_state_d;
  logic [CNT_WIDTH-1:0]   r_cnt, w_cnt_d, w_cnt_inc;
  logic                   r_bf_reset, r_bf_trigger, r_result_valid, r_busy, r_timeout_err;
  logic [LED_WIDTH-1:0]   r_led_out, w_led_d;
  logic                   w_result_valid_d, w_timeout_err_d;
  logic                   w_hit;

  sample_level_detect #(
    .DATA_WIDTH (DATA_WIDTH),
    .THRESHOLD  (THRESHOLD)
  ) u_level (
    .i_left_data  (i_left_data),
    .i_right_data (i_right_data),
    .o_hit        (w_hit)
  );

  // Saturating increment: the counter never wraps.
  assign w_cnt_inc = (&r_cnt) ? r_cnt : r_cnt + 1'b1;

  always_comb begin
    w_state_d        = r_state;
    w_cnt_d          = w_cnt_inc;
    w_led_d          = r_led_out;
    w_result_valid_d = 1'b0;
    w_timeout_err_d  = r_timeout_err;
    unique case (r_state)
      StIdle: begin
        w_cnt_d = '0;
        if (i_enable) w_state_d = StClear;
      end
      StClear: begin
        if (!i_enable) begin
          w_state_d = StIdle;
        end else if (r_cnt >= RESET_LAST) begin
          w_state_d = StFill;
          w_cnt_d   = '0;
        end
      end
      StFill: begin
        if (!i_enable) begin
          w_state_d = StIdle;
        end else if (r_cnt >= FILL_LAST) begin
          w_state_d = StArm;
          w_cnt_d   = '0;
        end
      end
      StArm: begin
        if (!i_enable) begin
          w_state_d = StIdle;
        end else if (w_hit) begin
          w_state_d = StCompute;
          w_cnt_d   = '0;
        end
      end
      StCompute: begin
        // A result on the final allowed cycle still wins over the timeout.
        if (i_bf_valid) begin
          w_state_d        = StHold;
          w_cnt_d          = '0;
          w_led_d          = i_bf_led_pattern;
          w_result_valid_d = 1'b1;
        end else if (r_cnt >= TIMEOUT_LAST) begin
          w_state_d       = StClear;
          w_cnt_d         = '0;
          w_timeout_err_d = 1'b1;
        end
      end
      StHold: begin
        if (r_cnt >= HOLD_LAST) begin
          w_state_d = i_enable ? StClear : StIdle;
          w_cnt_d   = '0;
        end
      end
      default: begin
        w_state_d = StIdle;
        w_cnt_d   = '0;
      end
    endcase
  end

  // Outputs are registered alongside the state they belong to.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state        <= StIdle;
      r_cnt          <= '0;
      r_bf_reset     <= 1'b1;
      r_bf_trigger   <= 1'b0;
      r_led_out      <= '0;
      r_result_valid <= 1'b0;
      r_busy         <= 1'b0;
      r_timeout_err  <= 1'b0;
    end else begin
      r_state        <= w_state_d;
      r_cnt          <= w_cnt_d;
      r_bf_reset     <= (w_state_d == StIdle) || (w_state_d == StClear);
      r_bf_trigger   <= (w_state_d == StCompute);
      r_led_out      <= w_led_d;
      r_result_valid <= w_result_valid_d;
      r_busy         <= (w_state_d != StIdle);
      r_timeout_err  <= w_timeout_err_d;
    end
  end

  assign o_bf_reset     = r_bf_reset;
  assign o_bf_trigger   = r_bf_trigger;
  assign o_led_out      = r_led_out;
  assign o_result_valid = r_result_valid;
  assign o_busy         = r_busy;
  assign o_timeout_err  = r_timeout_err;

endmodule

// File: tb/tb_beamforming_scheduler.sv
// Directed bench for beamforming_scheduler with a small result scoreboard.
module tb_beamforming_scheduler;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        enable;
  logic [15:0] left;
  logic [15:0] right;
  logic        valid;
  logic [7:0]  pattern;
  logic        bf_reset;
  logic        trig;
  logic [7:0]  led;
  logic        rv;
  logic        busy;
  logic        to;

  int          n_tests = 0;
  int          n_fail  = 0;
  int          n;
  int          m;
  logic        acc;
  logic [7:0]  exp_q[$];

  always #5 clk = ~clk;

  beamforming_scheduler #(
    .HOLD_CYCLES (20)
  ) dut (
    .i_clk            (clk),
    .i_rst_n          (rst_n),
    .i_enable         (enable),
    .i_left_data      (left),
    .i_right_data     (right),
    .i_bf_valid       (valid),
    .i_bf_led_pattern (pattern),
    .o_bf_reset       (bf_reset),
    .o_bf_trigger     (trig),
    .o_led_out        (led),
    .o_result_valid   (rv),
    .o_busy           (busy),
    .o_timeout_err    (to)
  );

  task automatic chk(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    n_tests++;
    assert (observed === expected)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Pops the scoreboard when a result pulse is expected and compares the latched pattern.
  task automatic check_result(input string tag);
    logic [7:0] e;
    chk({tag, "_rv"}, rv, 1);
    chk({tag, "_sb_pending"}, exp_q.size() > 0, 1);
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk({tag, "_led"}, led, e);
    end
  endtask

  task automatic check_reset_values(input string tag);
    chk({tag, "_bf_reset"}, bf_reset, 1);
    chk({tag, "_trig"}, trig, 0);
    chk({tag, "_led"}, led, 0);
    chk({tag, "_rv"}, rv, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_to"}, to, 0);
  endtask

  initial begin
    rst_n = 1'b0; enable = 1'b0; valid = 1'b0; left = '0; right = '0; pattern = '0;
    repeat (3) step();
    check_reset_values("rst");

    // Capture 1: clear length, quiet fill, left threshold boundary, result after 122 cycles.
    rst_n = 1'b1; enable = 1'b1;
    step();
    chk("busy_on", busy, 1);
    n = 0;
    while (bf_reset && n < 20) begin n++; step(); end
    chk("clear_len", n, 4);
    left = 16'h03FF; acc = 1'b0;
    for (int i = 0; i < 90; i++) begin acc |= trig | bf_reset; step(); end
    chk("fill_quiet", acc, 0);
    repeat (3) step();
    chk("trig_03ff", trig, 0);
    left = 16'h0400;
    step();
    chk("trig_0400", trig, 1);
    left = '0; acc = 1'b1;
    for (int i = 0; i < 121; i++) begin step(); acc &= trig; end
    chk("trig_held", acc, 1);
    valid = 1'b1; pattern = 8'h10; exp_q.push_back(8'h10);
    step();
    valid = 1'b0; pattern = '0;
    check_result("res1");
    chk("trig_drop", trig, 0);
    step();
    chk("rv_pulse", rv, 0);
    n = 1;
    while (!bf_reset && n < 100) begin step(); n++; end
    chk("hold_len", n, 20);
    chk("led_persist", led, 8'h10);

    // Capture 2: right = -32768 arms; exact fill length; result on the last allowed cycle.
    right = 16'h8000;
    n = 0;
    while (bf_reset && n < 20) begin step(); n++; end
    chk("clear_len2", n, 4);
    m = 0;
    while (!trig && m < 200) begin step(); m++; end
    chk("fill_len", m, 91);
    right = '0;
    for (int i = 0; i < 255; i++) step();
    valid = 1'b1; pattern = 8'hA5; exp_q.push_back(8'hA5);
    step();
    valid = 1'b0; pattern = '0;
    check_result("res_edge");
    chk("no_timeout", to, 0);
    n = 0;
    while (!bf_reset && n < 100) begin step(); n++; end
    chk("hold_len2", n, 20);

    // Capture 3: stray valid outside COMPUTE ignored; right = -1024 arms; engine timeout.
    valid = 1'b1; pattern = 8'hFF; acc = 1'b0;
    n = 0;
    while (bf_reset && n < 20) begin acc |= rv; step(); n++; end
    valid = 1'b0; pattern = '0; right = 16'hFC00;
    m = 0;
    while (!trig && m < 200) begin acc |= rv; step(); m++; end
    chk("stray_valid", acc, 0);
    chk("trig_fc00", trig, 1);
    right = '0; acc = 1'b0;
    for (int i = 0; i < 255; i++) begin acc |= to; step(); end
    chk("to_early", acc, 0);
    step();
    chk("to_set", to, 1);
    chk("to_reclear", bf_reset, 1);
    chk("to_led", led, 8'hA5);
    chk("to_trig", trig, 0);

    // Enable dropped during FILL returns to IDLE next cycle.
    n = 0;
    while (bf_reset && n < 20) begin step(); n++; end
    repeat (5) step();
    enable = 1'b0;
    step();
    chk("drop_busy", busy, 0);
    chk("drop_bf_reset", bf_reset, 1);
    chk("to_sticky", to, 1);

    // Capture 4, then asynchronous reset mid-HOLD.
    enable = 1'b1; left = 16'h0400;
    n = 0;
    while (!trig && n < 300) begin step(); n++; end
    chk("trig4", trig, 1);
    left = '0; valid = 1'b1; pattern = 8'h3C; exp_q.push_back(8'h3C);
    step();
    valid = 1'b0; pattern = '0;
    check_result("res4");
    repeat (3) step();
    #2 rst_n = 1'b0;
    #1 check_reset_values("async_rst");
    chk("sb_drained", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
